// File: rtl/axi4_seq_pkg.sv
// Shared types and timing defaults for the AXI4 burst sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      WBEAT,
      RBEAT,
      GAP
   } state_t;

   // Registered copy of an accepted command; the address lives in its own output register.
   typedef struct packed {
      logic       write;
      logic [3:0] len;
   } cmd_t;

   localparam int DEF_SETUP_CYC   = 3;
   localparam int DEF_RD_BEAT_CYC = 3;
   localparam int DEF_GAP_CYC     = 2;

   // Phase counter width covers any of the cycle parameters up to 255.
   localparam int CYC_W  = 8;
   // Beat counter is 5 bits so a 16-beat burst never wraps.
   localparam int BEAT_W = 5;

endpackage

// File: rtl/axi4_wdata_fifo.sv
// Generic synchronous FIFO holding write-burst data; show-ahead head word on pop_dat.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push_rdy low when full (push dropped); pop ignored when empty.
module axi4_wdata_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             core_clk,
   input  logic             arst,
   input  logic             push_vld,
   output logic             push_rdy,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic             pop_vld,
   output logic [WIDTH-1:0] pop_dat,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign push_rdy = (count != CNT_W'(DEPTH));
   assign pop_vld  = (count != '0);
   assign push_ok  = push_vld && push_rdy;
   assign pop_ok   = pop_rdy && pop_vld;
   assign pop_dat  = mem[rd_ptr];

   // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
   always_ff @(posedge core_clk or posedge arst) begin
      if (arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_next(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Storage array is not reset; emptiness is carried by the pointers and count.
   always_ff @(posedge core_clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/axi4_burst_sequencer.sv
// Turns burst commands into beat-by-beat write_s/read_s/LAST sequences for axi4_lite_top.
// Latency: SETUP_CYC cycles to first beat; 1 cycle/write beat, RD_BEAT_CYC cycles/read beat, then GAP_CYC idle.
// Backpressure: write commands wait in IDLE until the whole burst is buffered; wd_ready low when the FIFO is full.
module axi4_burst_sequencer
   import axi4_seq_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int SETUP_CYC   = DEF_SETUP_CYC,
   parameter int RD_BEAT_CYC = DEF_RD_BEAT_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [3:0]  cmd_len,
   input  logic        wd_valid,
   output logic        wd_ready,
   input  logic [31:0] wd_data,
   output logic        write_s,
   output logic        read_s,
   output logic        LAST,
   output logic [31:0] address,
   output logic [31:0] W_data,
   input  logic [31:0] R_data,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   state_t            state;
   cmd_t              cmd;
   logic [CYC_W-1:0]  cyc_cnt;
   logic [BEAT_W-1:0] beat_cnt;
   logic [BEAT_W-1:0] last_beat;
   logic [BEAT_W-1:0] need_beats;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [31:0]       fifo_head;
   logic              fifo_nempty;
   logic              fifo_pop;
   logic              setup_done;
   logic              rbeat_done;
   logic              gap_done;

   assign last_beat  = BEAT_W'(cmd.len);
   assign need_beats = BEAT_W'(cmd_len) + BEAT_W'(1);
   assign setup_done = (cyc_cnt == CYC_W'(SETUP_CYC - 1));
   assign rbeat_done = (cyc_cnt == CYC_W'(RD_BEAT_CYC - 1));
   assign gap_done   = (cyc_cnt == CYC_W'(GAP_CYC - 1));

   // A write is only accepted once every beat is already buffered, so beats never stall.
   // Gated by reset so no output is high while ARESET is held.
   assign cmd_ready = !ARESET && (state == IDLE) &&
                      (!cmd_write || (32'(fifo_cnt) >= 32'(need_beats)));

   // The word for each beat is popped one cycle ahead and registered onto W_data.
   assign fifo_pop = fifo_nempty &&
                     (((state == SETUP) && setup_done && cmd.write) ||
                      ((state == WBEAT) && (beat_cnt != last_beat)));

   axi4_wdata_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_wdata_fifo (
      .core_clk (ACLK),
      .arst     (ARESET),
      .push_vld (wd_valid),
      .push_rdy (wd_ready),
      .push_dat (wd_data),
      .pop_rdy  (fifo_pop),
      .pop_vld  (fifo_nempty),
      .pop_dat  (fifo_head),
      .count    (fifo_cnt)
   );

   // Burst FSM with all interface outputs registered.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state    <= IDLE;
         cmd      <= '0;
         cyc_cnt  <= '0;
         beat_cnt <= '0;
         write_s  <= 1'b0;
         read_s   <= 1'b0;
         LAST     <= 1'b0;
         address  <= '0;
         W_data   <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         busy     <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd.write <= cmd_write;
                  cmd.len   <= cmd_len;
                  address   <= cmd_addr;
                  write_s   <= cmd_write;
                  read_s    <= !cmd_write;
                  cyc_cnt   <= '0;
                  busy      <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (setup_done) begin
                  cyc_cnt  <= '0;
                  beat_cnt <= '0;
                  LAST     <= (cmd.len == 4'd0);
                  if (cmd.write) begin
                     W_data <= fifo_head;
                     state  <= WBEAT;
                  end else begin
                     state  <= RBEAT;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            WBEAT: begin
               if (beat_cnt == last_beat) begin
                  write_s <= 1'b0;
                  LAST    <= 1'b0;
                  W_data  <= '0;
                  cyc_cnt <= '0;
                  state   <= GAP;
               end else begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
                  W_data   <= fifo_head;
                  LAST     <= ((beat_cnt + BEAT_W'(1)) == last_beat);
               end
            end
            RBEAT: begin
               if (rbeat_done) begin
                  rd_data  <= R_data;
                  rd_valid <= 1'b1;
                  cyc_cnt  <= '0;
                  if (beat_cnt == last_beat) begin
                     read_s <= 1'b0;
                     LAST   <= 1'b0;
                     state  <= GAP;
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                     LAST     <= ((beat_cnt + BEAT_W'(1)) == last_beat);
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            GAP: begin
               if (gap_done) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
